// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch-side, data-side and unified-memory-side signals of
//   mem_port_arbiter. Signal names carry their direction as seen from the
//   arbiter: *_i are arbiter inputs and *_o are arbiter outputs.
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (pipeline stages and memory)
//   Signals:
//     if_req_i/if_addr_i/if_flush_i          fetch request, word address, redirect
//     if_valid_o/if_rdata_o/if_stall_o       fetch completion pulse, instruction, stall
//     dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i/dm_be_i  data request fields
//     dm_valid_o/dm_rdata_o/dm_stall_o       data completion pulse, load data, stall
//     mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o  unified memory request
//     mem_ready_i/mem_rdata_i                memory completion, read data
interface mem_port_arbiter_if;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_flush_i;
   logic        if_valid_o;
   logic [31:0] if_rdata_o;
   logic        if_stall_o;

   logic        dm_req_i;
   logic        dm_we_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic [3:0]  dm_be_i;
   logic        dm_valid_o;
   logic [31:0] dm_rdata_o;
   logic        dm_stall_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ready_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i, if_flush_i,
      output if_valid_o, if_rdata_o, if_stall_o,
      input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
      output dm_valid_o, dm_rdata_o, dm_stall_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_ready_i, mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i, if_flush_i,
      input  if_valid_o, if_rdata_o, if_stall_o,
      output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
      input  dm_valid_o, dm_rdata_o, dm_stall_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_ready_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between the instruction-fetch stage and the
//   data-memory stage. Exactly one transaction is outstanding at a time and
//   at least one IDLE cycle separates consecutive transactions. Data
//   requests normally win; a fetch that has lost STARVE_LIMIT consecutive
//   arbitrations is granted next. A redirect (if_flush_i) cancels a pending
//   or in-flight fetch without disturbing data traffic.
//   Parameters:
//     STARVE_LIMIT  consecutive data grants allowed while a fetch waits
//   Ports:
//     clk_i   single clock, rising edge
//     rst_ni  synchronous active-low reset
//     bus     mem_port_arbiter_if.slave (fetch, data and memory sides)
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic               clk_i,
   input logic               rst_ni,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_DM,
      BUSY_DROP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [3:0]       mem_be_q, mem_be_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             if_valid_q, if_valid_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic             dm_valid_q, dm_valid_d;
   logic [31:0]      dm_rdata_q, dm_rdata_d;

   logic             fetch_ok;
   logic             if_valid_gated;

   // A fetch arriving together with a redirect targets a stale address.
   assign fetch_ok = bus.if_req_i & ~bus.if_flush_i;

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_valid_d   = 1'b0;
      if_rdata_d   = if_rdata_q;
      dm_valid_d   = 1'b0;
      dm_rdata_d   = dm_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (bus.dm_req_i && !(fetch_ok && (starve_cnt_q == STARVE_MAX))) begin
               state_d     = BUSY_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we_i;
               mem_be_d    = bus.dm_be_i;
               mem_addr_d  = bus.dm_addr_i;
               mem_wdata_d = bus.dm_wdata_i;
               // Saturation is only reachable when a flushed fetch is waiting.
               if (bus.if_req_i) begin
                  if (starve_cnt_q != STARVE_MAX) begin
                     starve_cnt_d = starve_cnt_q + CNT_W'(1);
                  end
               end else begin
                  starve_cnt_d = '0;
               end
            end else if (fetch_ok) begin
               state_d      = BUSY_IF;
               mem_req_d    = 1'b1;
               mem_we_d     = 1'b0;
               mem_be_d     = '1;
               mem_addr_d   = bus.if_addr_i;
               mem_wdata_d  = '0;
               starve_cnt_d = '0;
            end
         end

         BUSY_IF: begin
            if (bus.mem_ready_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (!bus.if_flush_i) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = bus.mem_rdata_i;
               end
            end else if (bus.if_flush_i) begin
               state_d = BUSY_DROP;
            end
         end

         BUSY_DM: begin
            if (bus.mem_ready_i) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               dm_valid_d = 1'b1;
               dm_rdata_d = bus.mem_rdata_i;
            end
         end

         BUSY_DROP: begin
            if (bus.mem_ready_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_valid_q   <= 1'b0;
         if_rdata_q   <= '0;
         dm_valid_q   <= 1'b0;
         dm_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_valid_q   <= if_valid_d;
         if_rdata_q   <= if_rdata_d;
         dm_valid_q   <= dm_valid_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

   // A redirect in the completion cycle makes the returned instruction stale.
   assign if_valid_gated = if_valid_q & ~bus.if_flush_i;

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_be_o    = mem_be_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.if_valid_o  = if_valid_gated;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.dm_valid_o  = dm_valid_q;
   assign bus.dm_rdata_o  = dm_rdata_q;
   assign bus.if_stall_o  = bus.if_req_i & ~if_valid_gated;
   assign bus.dm_stall_o  = bus.dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A transaction-level model tracks the
//   outstanding request, arbitration fairness and completion pulses; one
//   compare process checks every output against it on each falling edge.
//   Directed scenarios add literal expectations on top.
module tb_mem_port_arbiter;
   localparam int unsigned LIMIT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] data_for(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'h7);
   endfunction

   // ---------------- memory responder ----------------
   int unsigned wait_n    = 0;
   int unsigned wcnt      = 0;
   bit          resp_en   = 1'b1;
   logic        man_ready = 1'b0;

   always @(negedge clk) begin
      if (!resp_en) begin
         bus.mem_ready_i <= man_ready;
      end else if (!rst_n) begin
         bus.mem_ready_i <= 1'b0;
         bus.mem_rdata_i <= '0;
         wcnt            <= 0;
      end else if (bus.mem_ready_i) begin
         bus.mem_ready_i <= 1'b0;
         wcnt            <= 0;
      end else if (bus.mem_req_o) begin
         if (wcnt == wait_n) begin
            bus.mem_ready_i <= 1'b1;
            bus.mem_rdata_i <= data_for(bus.mem_addr_o);
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   // ---------------- grant recorder ----------------
   logic [31:0] grant_addr [0:63];
   int          n_grants = 0;
   logic        prev_req = 1'b0;

   always @(negedge clk) begin
      if (bus.mem_req_o === 1'b1 && !prev_req && n_grants < 64) begin
         grant_addr[n_grants] <= bus.mem_addr_o;
         n_grants             <= n_grants + 1;
      end
      prev_req <= (bus.mem_req_o === 1'b1);
   end

   // ---------------- transaction-level model ----------------
   logic        m_live      = 1'b0;
   logic        m_busy      = 1'b0;
   logic        m_is_if     = 1'b0;
   logic        m_drop      = 1'b0;
   logic        m_we        = 1'b0;
   logic [3:0]  m_be        = '0;
   logic [31:0] m_addr      = '0;
   logic [31:0] m_wdata     = '0;
   int unsigned m_starve    = 0;
   logic        m_vif       = 1'b0;
   logic        m_vdm       = 1'b0;
   logic [31:0] m_rif       = '0;
   logic [31:0] m_rdm       = '0;
   logic        m_rdm_known = 1'b1;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_live      <= 1'b1;
         m_busy      <= 1'b0;
         m_drop      <= 1'b0;
         m_addr      <= '0;
         m_we        <= 1'b0;
         m_be        <= '0;
         m_wdata     <= '0;
         m_starve    <= 0;
         m_vif       <= 1'b0;
         m_vdm       <= 1'b0;
         m_rif       <= '0;
         m_rdm       <= '0;
         m_rdm_known <= 1'b1;
      end else begin
         m_vif <= 1'b0;
         m_vdm <= 1'b0;
         if (m_busy) begin
            if (bus.mem_ready_i) begin
               m_busy <= 1'b0;
               if (!m_is_if) begin
                  m_vdm <= 1'b1;
                  if (m_we) m_rdm_known <= 1'b0;
                  else begin
                     m_rdm       <= bus.mem_rdata_i;
                     m_rdm_known <= 1'b1;
                  end
               end else if (!m_drop && !bus.if_flush_i) begin
                  m_vif <= 1'b1;
                  m_rif <= bus.mem_rdata_i;
               end
            end else if (m_is_if && bus.if_flush_i) begin
               m_drop <= 1'b1;
            end
         end else if (bus.dm_req_i &&
                      !(bus.if_req_i && !bus.if_flush_i && m_starve == LIMIT)) begin
            m_busy   <= 1'b1;
            m_is_if  <= 1'b0;
            m_drop   <= 1'b0;
            m_addr   <= bus.dm_addr_i;
            m_we     <= bus.dm_we_i;
            m_be     <= bus.dm_be_i;
            m_wdata  <= bus.dm_wdata_i;
            m_starve <= bus.if_req_i ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
         end else if (bus.if_req_i && !bus.if_flush_i) begin
            m_busy   <= 1'b1;
            m_is_if  <= 1'b1;
            m_drop   <= 1'b0;
            m_addr   <= bus.if_addr_i;
            m_we     <= 1'b0;
            m_be     <= 4'hF;
            m_wdata  <= '0;
            m_starve <= 0;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_live) begin
         chk1("mem_req", bus.mem_req_o, m_busy);
         if (m_busy) begin
            chk32("mem_addr", bus.mem_addr_o, m_addr);
            chk1("mem_we", bus.mem_we_o, m_we);
            chk32("mem_be", 32'(bus.mem_be_o), 32'(m_be));
            chk32("mem_wdata", bus.mem_wdata_o, m_wdata);
         end
         chk1("if_valid", bus.if_valid_o, m_vif & ~bus.if_flush_i);
         chk1("dm_valid", bus.dm_valid_o, m_vdm);
         chk32("if_rdata", bus.if_rdata_o, m_rif);
         if (m_rdm_known) chk32("dm_rdata", bus.dm_rdata_o, m_rdm);
         chk1("if_stall", bus.if_stall_o, bus.if_req_i & ~(m_vif & ~bus.if_flush_i));
         chk1("dm_stall", bus.dm_stall_o, bus.dm_req_i & ~m_vdm);
      end
   end

   task automatic wait_idle(input string name);
      int unsigned t = 0;
      while (bus.mem_req_o && t < 20) begin
         step();
         t++;
      end
      chk1(name, bus.mem_req_o, 1'b0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int          base;
      int unsigned t;
      int unsigned pulses;
      int unsigned busy_cyc;
      logic [31:0] exp035 [6];
      logic [31:0] exp038 [5];

      exp035 = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h300, 32'h2000};
      exp038 = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h500};

      bus.if_req_i   = 1'b0;
      bus.if_addr_i  = '0;
      bus.if_flush_i = 1'b0;
      bus.dm_req_i   = 1'b0;
      bus.dm_we_i    = 1'b0;
      bus.dm_addr_i  = '0;
      bus.dm_wdata_i = '0;
      bus.dm_be_i    = '0;

      // reset state
      repeat (3) step();
      chk1("reset mem_req", bus.mem_req_o, 1'b0);
      chk1("reset if_valid", bus.if_valid_o, 1'b0);
      chk1("reset dm_valid", bus.dm_valid_o, 1'b0);
      chk32("reset mem_addr", bus.mem_addr_o, 32'h0);
      chk32("reset if_rdata", bus.if_rdata_o, 32'h0);
      rst_n = 1'b1;
      step();

      // zero-wait fetch latency
      wait_n        = 0;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h100;
      #1;
      chk1("034 stall N", bus.if_stall_o, 1'b1);
      step();
      chk1("034 mem_req N+1", bus.mem_req_o, 1'b1);
      chk32("034 mem_addr", bus.mem_addr_o, 32'h100);
      chk32("034 mem_be", 32'(bus.mem_be_o), 32'hF);
      chk1("034 mem_we", bus.mem_we_o, 1'b0);
      chk1("034 stall N+1", bus.if_stall_o, 1'b1);
      step();
      chk1("034 if_valid N+2", bus.if_valid_o, 1'b1);
      chk32("034 if_rdata", bus.if_rdata_o, 32'h0000_0013);
      bus.if_req_i = 1'b0;
      step();

      // starvation: four data grants, one fetch, then data again
      base           = n_grants;
      wait_n         = 1;
      bus.dm_addr_i  = 32'h2000;
      bus.dm_we_i    = 1'b0;
      bus.dm_be_i    = 4'hF;
      bus.if_addr_i  = 32'h300;
      bus.dm_req_i   = 1'b1;
      bus.if_req_i   = 1'b1;
      t = 0;
      while (n_grants < base + 6 && t < 80) begin
         step();
         t++;
      end
      chk1("035 grant budget", n_grants >= base + 6, 1'b1);
      bus.dm_req_i = 1'b0;
      bus.if_req_i = 1'b0;
      wait_idle("035 idle");
      for (int i = 0; i < 6; i++) chk32("035 grant order", grant_addr[base + i], exp035[i]);

      // reset during BUSY_DM with ready pending, then late ready in IDLE
      resp_en       = 1'b0;
      man_ready     = 1'b0;
      bus.dm_addr_i = 32'h80;
      bus.if_addr_i = 32'h500;
      bus.dm_req_i  = 1'b1;
      bus.if_req_i  = 1'b1;
      step();
      chk1("038 busy", bus.mem_req_o, 1'b1);
      chk32("038 addr", bus.mem_addr_o, 32'h80);
      rst_n        = 1'b0;
      man_ready    = 1'b1;
      bus.dm_req_i = 1'b0;
      bus.if_req_i = 1'b0;
      step();
      chk1("038 mem_req after reset", bus.mem_req_o, 1'b0);
      chk1("038 dm_valid after reset", bus.dm_valid_o, 1'b0);
      rst_n = 1'b1;
      step();
      chk1("038 late ready mem_req", bus.mem_req_o, 1'b0);
      chk1("038 late ready dm_valid", bus.dm_valid_o, 1'b0);
      man_ready = 1'b0;
      resp_en   = 1'b1;
      step();
      // starvation count restarts from zero after reset
      base         = n_grants;
      wait_n       = 0;
      bus.dm_req_i = 1'b1;
      bus.if_req_i = 1'b1;
      t = 0;
      while (n_grants < base + 5 && t < 80) begin
         step();
         t++;
      end
      chk1("038 grant budget", n_grants >= base + 5, 1'b1);
      bus.dm_req_i = 1'b0;
      bus.if_req_i = 1'b0;
      wait_idle("038 idle");
      for (int i = 0; i < 5; i++) chk32("038 grant order", grant_addr[base + i], exp038[i]);

      // flush one cycle after fetch grant, ready delayed 3 cycles
      wait_n        = 3;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h400;
      step();
      chk1("036 granted", bus.mem_req_o, 1'b1);
      bus.if_flush_i = 1'b1;
      bus.if_req_i   = 1'b0;
      step();
      bus.if_flush_i = 1'b0;
      chk1("036 drop holds req", bus.mem_req_o, 1'b1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.if_valid_o) pulses++;
         step();
      end
      chk32("036 if_valid pulses", pulses, 32'd0);
      chk1("036 back to idle", bus.mem_req_o, 1'b0);

      // store with two wait cycles
      wait_n         = 2;
      bus.dm_we_i    = 1'b1;
      bus.dm_be_i    = 4'b0011;
      bus.dm_addr_i  = 32'h40;
      bus.dm_wdata_i = 32'hDEAD_BEEF;
      bus.dm_req_i   = 1'b1;
      pulses   = 0;
      busy_cyc = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.mem_req_o) begin
            busy_cyc++;
            chk1("037 mem_we", bus.mem_we_o, 1'b1);
            chk32("037 mem_be", 32'(bus.mem_be_o), 32'h3);
            chk32("037 mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
            chk32("037 mem_addr", bus.mem_addr_o, 32'h40);
         end
         if (bus.dm_valid_o) begin
            pulses++;
            bus.dm_req_i = 1'b0;
         end
      end
      chk32("037 busy cycles", busy_cyc, 32'd3);
      chk32("037 dm_valid pulses", pulses, 32'd1);
      bus.dm_we_i = 1'b0;

      // fetch requested with a redirect in IDLE is not granted
      wait_n         = 0;
      bus.if_req_i   = 1'b1;
      bus.if_flush_i = 1'b1;
      bus.if_addr_i  = 32'h600;
      step();
      chk1("020 no grant on flush", bus.mem_req_o, 1'b0);
      bus.if_flush_i = 1'b0;
      step();
      chk1("020 grant after flush", bus.mem_req_o, 1'b1);
      chk32("020 addr", bus.mem_addr_o, 32'h600);
      step();
      chk1("020 if_valid", bus.if_valid_o, 1'b1);
      bus.if_req_i = 1'b0;
      step();

      // redirect in the completion cycle suppresses the pulse
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h700;
      step();
      step();
      bus.if_flush_i = 1'b1;
      bus.if_req_i   = 1'b0;
      #1;
      chk1("026 pulse suppressed", bus.if_valid_o, 1'b0);
      bus.if_flush_i = 1'b0;
      step();

      // redirect in the same cycle as ready: straight to IDLE, no pulse
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h800;
      step();
      bus.if_flush_i = 1'b1;
      bus.if_req_i   = 1'b0;
      step();
      bus.if_flush_i = 1'b0;
      chk1("025 no pulse", bus.if_valid_o, 1'b0);
      chk1("025 idle", bus.mem_req_o, 1'b0);
      step();

      // redirect has no effect on a data load
      wait_n        = 1;
      bus.dm_we_i   = 1'b0;
      bus.dm_addr_i = 32'h900;
      bus.dm_req_i  = 1'b1;
      step();
      bus.if_flush_i = 1'b1;
      step();
      chk1("027 still busy", bus.mem_req_o, 1'b1);
      step();
      chk1("027 dm_valid", bus.dm_valid_o, 1'b1);
      chk32("027 dm_rdata", bus.dm_rdata_o, 32'hC0DE_0907);
      bus.dm_req_i   = 1'b0;
      bus.if_flush_i = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
